// File: rtl/keypad_pkg.sv
// Shared encodings for the keypad scanner: scan-result kinds, key state and repeat timing.
package keypad_pkg;

    typedef enum logic [1:0] {
        ResNone  = 2'd0,
        ResKey   = 2'd1,
        ResChord = 2'd2
    } res_kind_e;

    typedef enum logic {
        StUp   = 1'b0,
        StDown = 1'b1
    } key_state_e;

    // Typematic timing in full scans: first repeat delay, then repeat period.
    localparam int unsigned REPEAT_FIRST = 32;
    localparam int unsigned REPEAT_NEXT  = 8;

endpackage

// File: rtl/keypad_debounce.sv
// Debounces full-scan results: a result must repeat DEBOUNCE times before it is committed.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CODE_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_done,
    input  res_kind_e         scan_kind,
    input  logic [CODE_W-1:0] scan_code,
    output logic              commit,
    output res_kind_e         commit_kind,
    output logic [CODE_W-1:0] commit_code
);

    localparam logic [3:0] DebMax = 4'(DEBOUNCE);

    res_kind_e         prev_kind_q;
    logic [CODE_W-1:0] prev_code_q;
    logic [3:0]        cnt_q;
    logic              same;
    logic [3:0]        cnt_next;
    logic              reach;

    always_comb begin
        // The code only distinguishes results of kind KEY.
        same = (scan_kind == prev_kind_q) &&
               ((scan_kind != ResKey) || (scan_code == prev_code_q));
        if (!same) begin
            cnt_next = 4'd1;
        end else if (cnt_q == DebMax) begin
            cnt_next = cnt_q;
        end else begin
            cnt_next = cnt_q + 4'd1;
        end
        // Commit only on arrival at DEBOUNCE, not on every saturated scan.
        reach = (cnt_next == DebMax) && !(same && (cnt_q == DebMax));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_kind_q <= ResNone;
            prev_code_q <= '0;
            cnt_q       <= '0;
            commit      <= 1'b0;
            commit_kind <= ResNone;
            commit_code <= '0;
        end else begin
            commit <= 1'b0;
            if (scan_done && (scan_kind != ResChord)) begin
                prev_kind_q <= scan_kind;
                prev_code_q <= scan_code;
                cnt_q       <= cnt_next;
                if (reach) begin
                    commit      <= 1'b1;
                    commit_kind <= scan_kind;
                    commit_code <= scan_code;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, debounced key code, level keydown and press events.
// Define KEYPAD_REPEAT_EN to add typematic repeat events while a key is held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned SCAN_DIV = 1024,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CODE_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] code,
    output logic              keydown,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic              overrun
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned COL_W = $clog2(COLS);

    logic [DIV_W-1:0]  div_q;
    logic [COL_W-1:0]  col_idx_q;
    logic [COLS-1:0]   col_q;
    logic [1:0]        hits_q;
    logic [CODE_W-1:0] first_q;

    logic              tick;
    logic              last_col;
    logic              scan_done;
    logic [1:0]        col_hits;
    logic [CODE_W-1:0] col_first;
    logic [CODE_W-1:0] cand;
    res_kind_e         scan_kind;

    logic              commit;
    res_kind_e         commit_kind;
    logic [CODE_W-1:0] commit_code;

    key_state_e        state_q;
    logic [CODE_W-1:0] code_q;
    logic              keydown_q;
    logic              ev_valid_q;
    logic              overrun_q;
    logic              accept;
    logic              press;
    logic              rep_fire;
    logic              raise;

    assign tick      = (div_q == DIV_W'(SCAN_DIV - 1));
    assign last_col  = (col_idx_q == COL_W'(COLS - 1));
    assign scan_done = tick && last_col;

    // Fold this column's rows into the running scan: hits saturate at 2, lowest code kept.
    always_comb begin
        col_hits  = hits_q;
        col_first = first_q;
        cand      = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!row[r]) begin
                cand = CODE_W'(r) * CODE_W'(COLS) + CODE_W'(col_idx_q);
                if ((col_hits == 2'd0) || (cand < col_first)) begin
                    col_first = cand;
                end
                if (col_hits != 2'd2) begin
                    col_hits = col_hits + 2'd1;
                end
            end
        end
        if (col_hits == 2'd0) begin
            scan_kind = ResNone;
        end else if (col_hits == 2'd1) begin
            scan_kind = ResKey;
        end else begin
            scan_kind = ResChord;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            col_idx_q <= '0;
            col_q     <= ~COLS'(1);
            hits_q    <= '0;
            first_q   <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
                col_q <= {col_q[COLS-2:0], col_q[COLS-1]};
                if (last_col) begin
                    col_idx_q <= '0;
                    hits_q    <= '0;
                    first_q   <= '0;
                end else begin
                    col_idx_q <= col_idx_q + 1'b1;
                    hits_q    <= col_hits;
                    first_q   <= col_first;
                end
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .CODE_W   (CODE_W)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .scan_done   (scan_done),
        .scan_kind   (scan_kind),
        .scan_code   (col_first),
        .commit      (commit),
        .commit_kind (commit_kind),
        .commit_code (commit_code)
    );

`ifdef KEYPAD_REPEAT_EN
    localparam logic [5:0] RepFireAt = 6'(REPEAT_FIRST - 1);
    localparam logic [5:0] RepReload = 6'(REPEAT_FIRST - REPEAT_NEXT);

    logic [5:0] rep_q;

    assign rep_fire = (state_q == StDown) && scan_done && (rep_q == RepFireAt);

    always_ff @(posedge clk) begin
        if (reset || commit) begin
            rep_q <= '0;
        end else if ((state_q == StDown) && scan_done) begin
            rep_q <= rep_fire ? RepReload : rep_q + 6'd1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        accept = ev_valid_q && ev_ready;
        press  = 1'b0;
        if (commit && (commit_kind == ResKey)) begin
            // A different key while down is a release plus a new press.
            press = (state_q == StUp) || (commit_code != code_q);
        end
        raise = press || rep_fire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StUp;
            code_q     <= '0;
            keydown_q  <= 1'b0;
            ev_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (commit && (commit_kind == ResKey)) begin
                state_q   <= StDown;
                keydown_q <= 1'b1;
                code_q    <= commit_code;
            end else if (commit && (commit_kind == ResNone)) begin
                state_q   <= StUp;
                keydown_q <= 1'b0;
            end

            if (raise) begin
                ev_valid_q <= 1'b1;
            end else if (accept) begin
                ev_valid_q <= 1'b0;
            end

            if (accept) begin
                overrun_q <= 1'b0;
            end else if (raise && ev_valid_q) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign col      = col_q;
    assign code     = code_q;
    assign keydown  = keydown_q;
    assign ev_valid = ev_valid_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a modelled 4x4 key matrix and an event scoreboard.
module tb_keypad_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int CODE_W   = 4;
    localparam int SCAN     = COLS * SCAN_DIV;
    localparam int LAT      = DEBOUNCE * SCAN + 2;
`ifdef KEYPAD_REPEAT_EN
    localparam int HOLD_EVENTS = 5;
`else
    localparam int HOLD_EVENTS = 1;
`endif

    typedef struct {
        int r;
        int c;
        int exp_code;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ROWS-1:0]   row;
    logic [COLS-1:0]   col;
    logic [CODE_W-1:0] code;
    logic              keydown;
    logic              ev_valid;
    logic              ev_ready = 1'b1;
    logic              overrun;

    bit keys [ROWS][COLS];
    int checks   = 0;
    int errors   = 0;
    int ev_count = 0;
    int ev_high  = 0;
    int exp_q [$];

    always #5 clk = ~clk;

    keypad_scanner #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE),
        .CODE_W   (CODE_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .code     (code),
        .keydown  (keydown),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .overrun  (overrun)
    );

    // Pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (keys[r][c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Scoreboard: every accepted event must match the oldest expected code.
    always @(negedge clk) begin
        if (!reset && ev_valid) ev_high++;
        if (!reset && ev_valid && ev_ready) begin
            ev_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got code %0d, expected no event", code);
            end else begin
                check("event_code", int'(code), exp_q.pop_front());
            end
        end
    end

    task automatic wait_keydown(input string name, input logic val, input int limit);
        int n = 0;
        while (keydown !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(keydown === val), 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        check("reset_col", int'(col), 'b1110);
        check("reset_code", int'(code), 0);
        check("reset_keydown", int'(keydown), 0);
        check("reset_ev_valid", int'(ev_valid), 0);
        check("reset_overrun", int'(overrun), 0);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs [7];
        int   base;
        vecs[0] = '{2, 1, 9};
        vecs[1] = '{0, 0, 0};
        vecs[2] = '{3, 3, 15};
        vecs[3] = '{1, 1, 5};
        vecs[4] = '{3, 0, 12};
        vecs[5] = '{0, 3, 3};
        vecs[6] = '{1, 2, 6};

        do_reset();

        // Single presses; the first one starts on a scan boundary right after reset.
        for (int i = 0; i < 7; i++) begin
            ev_high = 0;
            exp_q.push_back(vecs[i].exp_code);
            keys[vecs[i].r][vecs[i].c] = 1'b1;
            wait_keydown("press_keydown", 1'b1, (i == 0) ? LAT : LAT + SCAN);
            check("press_code", int'(code), vecs[i].exp_code);
            keys[vecs[i].r][vecs[i].c] = 1'b0;
            wait_keydown("release_keydown", 1'b0, LAT + SCAN);
            check("ev_valid_cycles", ev_high, 1);
            check("press_queue_drained", exp_q.size(), 0);
        end

        // Bounce: key 5 flips once per scan so no two consecutive scans agree.
        base = ev_count;
        @(posedge clk); #1;
        for (int t = 0; t < 13; t++) begin
            keys[1][1] = !keys[1][1];
            idle(SCAN);
        end
        check("bounce_no_event", ev_count - base, 0);
        check("bounce_keydown", int'(keydown), 0);
        exp_q.push_back(5);
        wait_keydown("bounce_hold_keydown", 1'b1, LAT + SCAN);
        check("bounce_code", int'(code), 5);
        keys[1][1] = 1'b0;
        wait_keydown("bounce_release", 1'b0, LAT + SCAN);
        check("bounce_one_event", ev_count - base, 1);

        // Chord of keys 0 and 15 is ignored; releasing 15 leaves a clean key 0.
        base = ev_count;
        @(posedge clk); #1;
        keys[0][0] = 1'b1;
        keys[3][3] = 1'b1;
        idle(6 * SCAN);
        check("chord_keydown", int'(keydown), 0);
        check("chord_no_event", ev_count - base, 0);
        exp_q.push_back(0);
        keys[3][3] = 1'b0;
        wait_keydown("chord_release15_keydown", 1'b1, LAT + SCAN);
        check("chord_code", int'(code), 0);
        keys[0][0] = 1'b0;
        wait_keydown("chord_release", 1'b0, LAT + SCAN);

        // Overrun: second press while the first event is still pending.
        @(posedge clk); #1;
        ev_ready = 1'b0;
        keys[0][3] = 1'b1;
        wait_keydown("ovr_press3", 1'b1, LAT + SCAN);
        check("ovr_first_valid", int'(ev_valid), 1);
        check("ovr_first_code", int'(code), 3);
        keys[0][3] = 1'b0;
        wait_keydown("ovr_release3", 1'b0, LAT + SCAN);
        check("ovr_still_pending", int'(ev_valid), 1);
        check("ovr_no_overrun_yet", int'(overrun), 0);
        keys[1][3] = 1'b1;
        wait_keydown("ovr_press7", 1'b1, LAT + SCAN);
        check("ovr_valid", int'(ev_valid), 1);
        check("ovr_code", int'(code), 7);
        check("ovr_flag", int'(overrun), 1);
        exp_q.push_back(7);
        @(posedge clk); #1;
        ev_ready = 1'b1;
        @(posedge clk); #1;
        ev_ready = 1'b0;
        @(negedge clk);
        check("ovr_accept_valid", int'(ev_valid), 0);
        check("ovr_accept_flag", int'(overrun), 0);
        check("ovr_queue_drained", exp_q.size(), 0);
        keys[1][3] = 1'b0;
        wait_keydown("ovr_release7", 1'b0, LAT + SCAN);
        ev_ready = 1'b1;

        // Long hold of key 10: a single event, or typematic repeats when enabled.
        base = ev_count;
        for (int i = 0; i < HOLD_EVENTS; i++) exp_q.push_back(10);
        @(posedge clk); #1;
        keys[2][2] = 1'b1;
        idle(61 * SCAN);
        check("hold_event_count", ev_count - base, HOLD_EVENTS);
        check("hold_code", int'(code), 10);
        keys[2][2] = 1'b0;
        wait_keydown("hold_release", 1'b0, LAT + SCAN);
        check("hold_queue_drained", exp_q.size(), 0);

        // Reset while an event is pending discards it.
        @(posedge clk); #1;
        ev_ready = 1'b0;
        keys[1][2] = 1'b1;
        wait_keydown("rst_press", 1'b1, LAT + SCAN);
        check("rst_pending_valid", int'(ev_valid), 1);
        keys[1][2] = 1'b0;
        do_reset();
        ev_ready = 1'b1;
        base = ev_count;
        idle(4 * SCAN);
        check("rst_no_event_after", ev_count - base, 0);
        check("rst_keydown_after", int'(keydown), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
